// File: rtl/rf_wb_arbiter_if.sv
// Write-back request/grant bundle between two requesters, the arbiter and the register-file write port.
// Forwarding signals exist only when RF_WB_FWD_EN is defined.
interface rf_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              arb_en;
  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              rg_wrt_en;
  logic [ADDR_W-1:0] rg_wrt_add;
  logic [DATA_W-1:0] rg_wrt_data;
  logic [CNT_W-1:0]  gnt_cnt0;
  logic [CNT_W-1:0]  gnt_cnt1;
`ifdef RF_WB_FWD_EN
  logic [ADDR_W-1:0] fwd_rd_ad1;
  logic [ADDR_W-1:0] fwd_rd_ad2;
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data1;
  logic [DATA_W-1:0] fwd_data2;
`endif

  modport master (
    output arb_en, req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
`ifdef RF_WB_FWD_EN
    output fwd_rd_ad1, fwd_rd_ad2,
    input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
`endif
    input  req0_ready, req1_ready, rg_wrt_en, rg_wrt_add, rg_wrt_data, gnt_cnt0, gnt_cnt1
  );

  modport slave (
    input  arb_en, req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
`ifdef RF_WB_FWD_EN
    input  fwd_rd_ad1, fwd_rd_ad2,
    output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
`endif
    output req0_ready, req1_ready, rg_wrt_en, rg_wrt_add, rg_wrt_data, gnt_cnt0, gnt_cnt1
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the register-file write port: one grant per cycle, 1-cycle registered write, x0 writes dropped.
// Never back-pressures downstream; saturating grant counters. RF_WB_FWD_EN adds write-stage forwarding.
module rf_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input logic           clk,
  input logic           rst,
  rf_wb_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              gnt0;
  logic              gnt1;
  logic              rr_ptr_q,   rr_ptr_d;
  logic              wr_en_q,    wr_en_d;
  logic [ADDR_W-1:0] wr_add_q,   wr_add_d;
  logic [DATA_W-1:0] wr_data_q,  wr_data_d;
  logic [CNT_W-1:0]  cnt0_q,     cnt0_d;
  logic [CNT_W-1:0]  cnt1_q,     cnt1_d;

  // rr_ptr only breaks ties; a lone requester always wins
  always_comb begin
    gnt0 = bus.arb_en && bus.req0_valid && (!bus.req1_valid || !rr_ptr_q);
    gnt1 = bus.arb_en && bus.req1_valid && (!bus.req0_valid ||  rr_ptr_q);
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    wr_en_d   = 1'b0;
    wr_add_d  = wr_add_q;
    wr_data_d = wr_data_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    if (gnt0) begin
      rr_ptr_d  = 1'b1;
      wr_en_d   = (bus.req0_addr != '0);
      wr_add_d  = bus.req0_addr;
      wr_data_d = bus.req0_data;
      if (cnt0_q != CNT_MAX) cnt0_d = cnt0_q + CNT_W'(1);
    end else if (gnt1) begin
      rr_ptr_d  = 1'b0;
      wr_en_d   = (bus.req1_addr != '0);
      wr_add_d  = bus.req1_addr;
      wr_data_d = bus.req1_data;
      if (cnt1_q != CNT_MAX) cnt1_d = cnt1_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_add_q  <= '0;
      wr_data_q <= '0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      wr_en_q   <= wr_en_d;
      wr_add_q  <= wr_add_d;
      wr_data_q <= wr_data_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
    end
  end

  assign bus.req0_ready  = gnt0;
  assign bus.req1_ready  = gnt1;
  assign bus.rg_wrt_en   = wr_en_q;
  assign bus.rg_wrt_add  = wr_add_q;
  assign bus.rg_wrt_data = wr_data_q;
  assign bus.gnt_cnt0    = cnt0_q;
  assign bus.gnt_cnt1    = cnt1_q;

`ifdef RF_WB_FWD_EN
  // The register file shows this write only after the edge, so bypass it to same-cycle readers
  logic hit1;
  logic hit2;
  assign hit1          = wr_en_q && (wr_add_q == bus.fwd_rd_ad1) && (bus.fwd_rd_ad1 != '0);
  assign hit2          = wr_en_q && (wr_add_q == bus.fwd_rd_ad2) && (bus.fwd_rd_ad2 != '0);
  assign bus.fwd_hit1  = hit1;
  assign bus.fwd_hit2  = hit2;
  assign bus.fwd_data1 = hit1 ? wr_data_q : '0;
  assign bus.fwd_data2 = hit2 ? wr_data_q : '0;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed stimulus queues expected writes, a negedge monitor checks the write port.
`timescale 1ns/1ps
module tb_rf_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();
  rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every write pulse must match the oldest expected write in its due cycle
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (bus.rg_wrt_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                   bus.rg_wrt_add, bus.rg_wrt_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(bus.rg_wrt_add), 32'(e.addr));
          check("wr_data", bus.rg_wrt_data, e.data);
          check("wr_cycle", 32'(cyc), 32'(e.due));
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        n_checks++;
        $display("FAIL missed_write: got rg_wrt_en 0, expected write addr 0x%0h in cycle %0d",
                 exp_q[0].addr, exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1; drives one cycle, checks ready, queues the expected write
  task automatic step(input logic en,
                      input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic er0, input logic er1, input string tag);
    bus.arb_en     = en;
    bus.req0_valid = v0;
    bus.req0_addr  = a0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_addr  = a1;
    bus.req1_data  = d1;
    @(negedge clk);
    check({tag, "_ready0"}, 32'(bus.req0_ready), 32'(er0));
    check({tag, "_ready1"}, 32'(bus.req1_ready), 32'(er1));
    if (er0 && a0 != '0) exp_q.push_back('{a0, d0, cyc + 1});
    if (er1 && a1 != '0) exp_q.push_back('{a1, d1, cyc + 1});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, tag);
  endtask

  task automatic do_reset();
    bus.arb_en     = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_addr  = '0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_addr  = '0;
    bus.req1_data  = '0;
`ifdef RF_WB_FWD_EN
    bus.fwd_rd_ad1 = '0;
    bus.fwd_rd_ad2 = '0;
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    do_reset();
    check("rst_wr_en", 32'(bus.rg_wrt_en), 0);
    check("rst_wr_add", 32'(bus.rg_wrt_add), 0);
    check("rst_cnt0", 32'(bus.gnt_cnt0), 0);
    check("rst_cnt1", 32'(bus.gnt_cnt1), 0);
    for (int i = 0; i < 3; i++) idle("idle");

    // Single requester
    step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b1, 1'b0, "single");
    check("single_cnt0", 32'(bus.gnt_cnt0), 1);
    check("single_cnt1", 32'(bus.gnt_cnt1), 0);
    idle("single_drain");

    // Contention from reset alternates 0,1,0,1
    do_reset();
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, (i % 2) == 0, (i % 2) == 1, "contend");
    idle("contend_drain");
    check("contend_cnt0", 32'(bus.gnt_cnt0), 2);
    check("contend_cnt1", 32'(bus.gnt_cnt1), 2);

    // x0 write is accepted and counted but never reaches the write port
    step(1'b1, 1'b0, '0, '0, 1'b1, 5'd0, 32'h1234, 1'b0, 1'b1, "x0");
    check("x0_wr_en", 32'(bus.rg_wrt_en), 0);
    check("x0_cnt1", 32'(bus.gnt_cnt1), 3);
    idle("x0_drain");

    // arb_en low holds everything, including the round-robin pointer
    do_reset();
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 1'b0, 1'b0, "arb_off");
    step(1'b1, 1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 1'b1, 1'b0, "arb_on0");
    step(1'b1, 1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 1'b0, 1'b1, "arb_on1");
    step(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 1'b0, 1'b0, "arb_midoff");
    idle("arb_drain");
    check("arb_cnt0", 32'(bus.gnt_cnt0), 1);
    check("arb_cnt1", 32'(bus.gnt_cnt1), 1);

`ifdef RF_WB_FWD_EN
    step(1'b1, 1'b1, 5'd7, 32'hCAFE0007, 1'b0, '0, '0, 1'b1, 1'b0, "fwd");
    bus.fwd_rd_ad1 = 5'd7;
    bus.fwd_rd_ad2 = 5'd0;
    #1;
    check("fwd_hit1", 32'(bus.fwd_hit1), 1);
    check("fwd_data1", bus.fwd_data1, 32'hCAFE0007);
    check("fwd_hit2_x0", 32'(bus.fwd_hit2), 0);
    check("fwd_data2_x0", bus.fwd_data2, 0);
    bus.fwd_rd_ad1 = 5'd8;
    #1;
    check("fwd_miss_hit1", 32'(bus.fwd_hit1), 0);
    check("fwd_miss_data1", bus.fwd_data1, 0);
    bus.fwd_rd_ad1 = '0;
    idle("fwd_drain");
`endif

    // Saturation: 20 transfers into a 4-bit counter
    do_reset();
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b1, 5'd3, 32'(i + 32'h100), 1'b0, '0, '0, 1'b1, 1'b0, "sat");
    idle("sat_drain");
    check("sat_cnt0", 32'(bus.gnt_cnt0), 15);
    check("sat_cnt1", 32'(bus.gnt_cnt1), 0);

    // Asynchronous reset in the middle of a live write discards it
    step(1'b1, 1'b0, '0, '0, 1'b1, 5'd12, 32'h5A5A, 1'b0, 1'b1, "arst");
    void'(exp_q.pop_back());
    check("arst_pre_wr_en", 32'(bus.rg_wrt_en), 1);
    check("arst_pre_cnt1", 32'(bus.gnt_cnt1), 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_wr_en", 32'(bus.rg_wrt_en), 0);
    check("arst_cnt0", 32'(bus.gnt_cnt0), 0);
    check("arst_cnt1", 32'(bus.gnt_cnt1), 0);
    check("arst_wr_add", 32'(bus.rg_wrt_add), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, 1'b1, 1'b0, "post_rst");
    idle("post_rst_drain");
    idle("final_drain");

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Round-robin arbiter sharing the single register-file write port between two write-back requesters: req0 (ALU/execute) and req1 (load/store unit). One transfer is granted per cycle and registered into an output stage that drives the register-file write port (rg_wrt_en / rg_wrt_add / rg_wrt_data). Writes to x0 are filtered out. Saturating per-requester grant counters are included for performance monitoring.

Parameters:
DATA_W, 32, write-data width
ADDR_W, 5, register address width
CNT_W, 16, width of each grant counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
arb_en  in  1  arbitration enable; 0 = no grants
req0_valid  in  1  requester 0 has a write
req0_ready  out  1  requester 0 transfer accepted this cycle
req0_addr  in  ADDR_W  requester 0 destination register
req0_data  in  DATA_W  requester 0 write data
req1_valid  in  1  requester 1 has a write
req1_ready  out  1  requester 1 transfer accepted this cycle
req1_addr  in  ADDR_W  requester 1 destination register
req1_data  in  DATA_W  requester 1 write data
rg_wrt_en  out  1  register-file write enable
rg_wrt_add  out  ADDR_W  register-file write address
rg_wrt_data  out  DATA_W  register-file write data
gnt_cnt0  out  CNT_W  accepted-transfer count, requester 0
gnt_cnt1  out  CNT_W  accepted-transfer count, requester 1

Behaviour:
- Reset (rst=1, asynchronous, active-high; clock clk): rg_wrt_en=0, rg_wrt_add=0, rg_wrt_data=0, gnt_cnt0=0, gnt_cnt1=0, rr_ptr=0. A write held in the output stage when reset asserts is discarded.
- Ready outputs are combinational from the valid inputs, arb_en and rr_ptr. The valid inputs must not depend on ready. A transfer occurs when valid && ready. Requesters hold addr/data stable while valid is high and ready is low.
- Grant rule, when arb_en=1:
  - Only reqN valid: reqN is granted.
  - Both valid: the requester indexed by rr_ptr is granted.
  - Neither valid: no grant.
- When arb_en=0: both ready outputs are 0.
- At most one ready is high in any cycle.
- rr_ptr update: on any grant to N, rr_ptr <= 1-N at the next edge. With no grant, rr_ptr holds. Under continuous contention the grants therefore alternate 0,1,0,1.
- Output stage (1-cycle latency): on the edge after a grant, rg_wrt_add and rg_wrt_data take the granted addr/data, and rg_wrt_en <= (granted addr != 0).
  - With no grant, rg_wrt_en <= 0. rg_wrt_add and rg_wrt_data hold their previous values.
  - The write port is consumed every cycle, so the output stage never back-pressures.
- x0 filter: a request with addr=0 is still accepted (ready=1) and counted, but produces no write pulse.
- Counters: gnt_cntN increments on each accepted reqN transfer, including x0 writes. Each counter saturates at 2^CNT_W-1 and does not wrap. Counters are cleared only by rst.
- Clearing arb_en mid-stream: no new grants are made, and an already-registered write still completes on its cycle.

Optional Feature:
Macro RF_WB_FWD_EN.
- When defined, the block adds these ports:
  - fwd_rd_ad1 in ADDR_W
  - fwd_rd_ad2 in ADDR_W
  - fwd_hit1 out 1
  - fwd_hit2 out 1
  - fwd_data1 out DATA_W
  - fwd_data2 out DATA_W
- Forwarding logic is combinational: fwd_hitK = rg_wrt_en && (rg_wrt_add == fwd_rd_adK) && (fwd_rd_adK != 0), and fwd_dataK = rg_wrt_data when fwd_hitK=1, else 0.
- Purpose: forward data being written in the current cycle, which the register file exposes only after the clock edge.
- When not defined, these ports and this logic are absent. All other behaviour is identical.

Test Plan:
- Reset then idle: rst pulse with all valids 0 -> rg_wrt_en=0, gnt_cnt0=gnt_cnt1=0, both ready=0 every cycle.
- Single requester: req0_valid=1, addr=5, data=0xDEADBEEF for one cycle -> req0_ready=1 in the same cycle; next cycle rg_wrt_en=1, rg_wrt_add=5, rg_wrt_data=0xDEADBEEF; gnt_cnt0=1.
- Contention: both valid for 4 cycles (req0 addr=1/data=0x11, req1 addr=2/data=0x22) after reset -> grants 0,1,0,1; write port shows addr 1,2,1,2 one cycle later; gnt_cnt0=gnt_cnt1=2.
- x0 filter: req1_valid=1, addr=0, data=0x1234 -> req1_ready=1; next cycle rg_wrt_en=0; gnt_cnt1 increments by 1.
- arb_en low: both valid with arb_en=0 for 3 cycles -> no ready, no write pulses, rr_ptr unchanged; arb_en=1 -> req0 granted first after reset.
- Saturation and reset: with CNT_W=4, 20 req0 transfers -> gnt_cnt0=15; assert rst asynchronously mid-write -> rg_wrt_en drops immediately and counters read 0. With RF_WB_FWD_EN defined: write to addr 7 and fwd_rd_ad1=7 -> fwd_hit1=1 and fwd_data1 equals the write data during the write cycle.
